// File: rtl/lfsr_gen.sv
// Fibonacci XNOR LFSR word generator with valid/ready output, leap-forward stepping,
// seed loading with lock-up protection and a full-period completion pulse.
module lfsr_gen #(
    parameter int unsigned NUM_BITS = 16,
    parameter int unsigned OUT_BITS = 8
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                i_Enable,
    input  logic                i_Seed_DV,
    input  logic [NUM_BITS-1:0] i_Seed_Data,
    input  logic                i_Ready,
    output logic                o_Valid,
    output logic [NUM_BITS-1:0] o_LFSR_Data,
    output logic [OUT_BITS-1:0] o_Word,
    output logic                o_LFSR_Done,
    output logic                o_Seed_Err
);

    localparam int unsigned CNT_W = NUM_BITS + 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Maximal-length tap masks: a tap listed as n (1-based) sets bit n-1.
    function automatic logic [31:0] tap_mask(input int unsigned n);
        case (n)
            3:       tap_mask = 32'h0000_0006;
            4:       tap_mask = 32'h0000_000C;
            5:       tap_mask = 32'h0000_0014;
            6:       tap_mask = 32'h0000_0030;
            7:       tap_mask = 32'h0000_0060;
            8:       tap_mask = 32'h0000_00B8;
            9:       tap_mask = 32'h0000_0110;
            10:      tap_mask = 32'h0000_0240;
            11:      tap_mask = 32'h0000_0500;
            12:      tap_mask = 32'h0000_0829;
            13:      tap_mask = 32'h0000_100D;
            14:      tap_mask = 32'h0000_2015;
            15:      tap_mask = 32'h0000_6000;
            16:      tap_mask = 32'h0000_D008;
            17:      tap_mask = 32'h0001_2000;
            18:      tap_mask = 32'h0002_0400;
            19:      tap_mask = 32'h0004_0023;
            20:      tap_mask = 32'h0009_0000;
            21:      tap_mask = 32'h0014_0000;
            22:      tap_mask = 32'h0030_0000;
            23:      tap_mask = 32'h0042_0000;
            24:      tap_mask = 32'h00E1_0000;
            25:      tap_mask = 32'h0120_0000;
            26:      tap_mask = 32'h0200_0023;
            27:      tap_mask = 32'h0400_0013;
            28:      tap_mask = 32'h0900_0000;
            29:      tap_mask = 32'h1400_0000;
            30:      tap_mask = 32'h2000_0029;
            31:      tap_mask = 32'h4800_0000;
            32:      tap_mask = 32'h8020_0003;
            default: tap_mask = 32'h0000_0000;
        endcase
    endfunction

    localparam logic [NUM_BITS-1:0] TAPS     = NUM_BITS'(tap_mask(NUM_BITS));
    localparam logic [NUM_BITS-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0]    PERIOD   = {1'b0, ALL_ONES};

    function automatic logic [NUM_BITS-1:0] lfsr_step(input logic [NUM_BITS-1:0] s);
        lfsr_step = {s[NUM_BITS-2:0], ~^(s & TAPS)};
    endfunction

    logic [0:0]          fsm_q, fsm_d;
    logic [NUM_BITS-1:0] lfsr_q, lfsr_d, leap;
    logic [NUM_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_sum;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                xfer;

    // State registers
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            fsm_q  <= ST_IDLE;
            lfsr_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    // Next-state: seed load wins over a simultaneous transfer
    always_comb begin
        fsm_d  = fsm_q;
        lfsr_d = lfsr_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        err_d  = 1'b0;

        leap = lfsr_q;
        for (int i = 0; i < int'(OUT_BITS); i++) begin
            leap = lfsr_step(leap);
        end
        cnt_sum = {1'b0, cnt_q} + CNT_W'(OUT_BITS);
        xfer    = (fsm_q == ST_RUN) && i_Enable && i_Ready;

        if ((fsm_q == ST_IDLE) && (i_Seed_DV || i_Enable)) begin
            fsm_d = ST_RUN;
        end

        if (i_Seed_DV) begin
            cnt_d = '0;
            if (i_Seed_Data == ALL_ONES) begin
                lfsr_d = '0;
                err_d  = 1'b1;
            end else begin
                lfsr_d = i_Seed_Data;
            end
        end else if (xfer) begin
            lfsr_d = leap;
            if (cnt_sum >= PERIOD) begin
                cnt_d  = NUM_BITS'(cnt_sum - PERIOD);
                done_d = 1'b1;
            end else begin
                cnt_d = NUM_BITS'(cnt_sum);
            end
        end
    end

    assign o_Valid     = (fsm_q == ST_RUN) && i_Enable;
    assign o_LFSR_Data = lfsr_q;
    assign o_Word      = lfsr_q[OUT_BITS-1:0];
    assign o_LFSR_Done = done_q;
    assign o_Seed_Err  = err_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: three configurations share one stimulus stream and are
// compared against a step-count based reference model plus directed sequences.
module tb_lfsr_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        sdv;
    logic [15:0] seed;
    logic        rdy;

    logic        d1_valid, d4_valid, d16_valid;
    logic [3:0]  d1_data, d4_data;
    logic [15:0] d16_data;
    logic [0:0]  d1_word;
    logic [3:0]  d4_word;
    logic [7:0]  d16_word;
    logic        d1_done, d4_done, d16_done;
    logic        d1_err, d4_err, d16_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_gen #(.NUM_BITS(4), .OUT_BITS(1)) u_d1 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en), .i_Seed_DV(sdv),
        .i_Seed_Data(seed[3:0]), .i_Ready(rdy), .o_Valid(d1_valid),
        .o_LFSR_Data(d1_data), .o_Word(d1_word), .o_LFSR_Done(d1_done),
        .o_Seed_Err(d1_err)
    );

    lfsr_gen #(.NUM_BITS(4), .OUT_BITS(4)) u_d4 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en), .i_Seed_DV(sdv),
        .i_Seed_Data(seed[3:0]), .i_Ready(rdy), .o_Valid(d4_valid),
        .o_LFSR_Data(d4_data), .o_Word(d4_word), .o_LFSR_Done(d4_done),
        .o_Seed_Err(d4_err)
    );

    lfsr_gen #(.NUM_BITS(16), .OUT_BITS(8)) u_d16 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en), .i_Seed_DV(sdv),
        .i_Seed_Data(seed), .i_Ready(rdy), .o_Valid(d16_valid),
        .o_LFSR_Data(d16_data), .o_Word(d16_word), .o_LFSR_Done(d16_done),
        .o_Seed_Err(d16_err)
    );

    logic [31:0] ob_valid [3];
    logic [31:0] ob_data  [3];
    logic [31:0] ob_word  [3];
    logic [31:0] ob_done  [3];
    logic [31:0] ob_err   [3];

    assign ob_valid[0] = 32'(d1_valid);
    assign ob_valid[1] = 32'(d4_valid);
    assign ob_valid[2] = 32'(d16_valid);
    assign ob_data[0]  = 32'(d1_data);
    assign ob_data[1]  = 32'(d4_data);
    assign ob_data[2]  = 32'(d16_data);
    assign ob_word[0]  = 32'(d1_word);
    assign ob_word[1]  = 32'(d4_word);
    assign ob_word[2]  = 32'(d16_word);
    assign ob_done[0]  = 32'(d1_done);
    assign ob_done[1]  = 32'(d4_done);
    assign ob_done[2]  = 32'(d16_done);
    assign ob_err[0]   = 32'(d1_err);
    assign ob_err[1]   = 32'(d4_err);
    assign ob_err[2]   = 32'(d16_err);

    // Reference model: width, word size and 0-based tap positions per configuration
    int unsigned nb [3] = '{4, 4, 16};
    int unsigned ob [3] = '{1, 4, 8};
    logic [31:0] tp [3] = '{32'h0000_000C, 32'h0000_000C, 32'h0000_D008};

    logic [31:0] m_st    [3];
    longint      m_steps [3];
    logic        m_done  [3];
    logic        m_err   [3];
    logic        m_run;

    function automatic logic [31:0] mask_of(input int unsigned n);
        mask_of = 32'((64'd1 << n) - 64'd1);
    endfunction

    // Feedback is 1 when an even number of tap bits are set (XNOR of taps)
    function automatic logic [31:0] ref_next(input logic [31:0] s, input int i);
        logic fb;
        fb = (($countones(s & tp[i]) % 2) == 0);
        ref_next = ((s << 1) | 32'(fb)) & mask_of(nb[i]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i]    = '0;
            m_steps[i] = 0;
            m_done[i]  = 1'b0;
            m_err[i]   = 1'b0;
        end
        m_run = 1'b0;
    endtask

    task automatic model_edge();
        longint per;
        longint old;
        logic   xfer;
        logic [31:0] sv;
        if (!rst_n) begin
            model_reset();
        end else begin
            xfer = m_run && en && rdy;
            for (int i = 0; i < 3; i++) begin
                per       = longint'(mask_of(nb[i]));
                m_done[i] = 1'b0;
                m_err[i]  = 1'b0;
                if (sdv) begin
                    sv = 32'(seed) & mask_of(nb[i]);
                    if (sv == mask_of(nb[i])) begin
                        m_st[i]  = '0;
                        m_err[i] = 1'b1;
                    end else begin
                        m_st[i] = sv;
                    end
                    m_steps[i] = 0;
                end else if (xfer) begin
                    old        = m_steps[i];
                    m_steps[i] = m_steps[i] + longint'(ob[i]);
                    for (int k = 0; k < int'(ob[i]); k++) m_st[i] = ref_next(m_st[i], i);
                    m_done[i] = (m_steps[i] / per) != (old / per);
                end
            end
            m_run = m_run || sdv || en;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_valid", i), ob_valid[i], 32'(m_run && en));
            chk($sformatf("d%0d_data", i), ob_data[i], m_st[i]);
            chk($sformatf("d%0d_word", i), ob_word[i], m_st[i] & mask_of(ob[i]));
            chk($sformatf("d%0d_done", i), ob_done[i], 32'(m_done[i]));
            chk($sformatf("d%0d_err", i), ob_err[i], 32'(m_err[i]));
        end
    endtask

    // Check settled outputs, clock once, advance the model, leave inputs free to change
    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [16];
        int d16_dones;
        seq = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};

        rst_n = 1'b0; en = 1'b0; sdv = 1'b0; seed = '0; rdy = 1'b0;
        model_reset();
        tick();
        tick();

        // Free run from reset state 0
        rst_n = 1'b1; en = 1'b1; rdy = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            chk("seq_from_reset", 32'(d1_data), 32'(seq[k]));
            chk("done_full_period", 32'(d1_done), 32'(k == 15));
            if (k == 1) chk("leap4_first", 32'(d4_data), 32'hE);
            if (k <= 5) chk("leap4_done", 32'(d4_done), 32'(k == 4));
            tick();
        end

        // Seed 0x7 then a full period back to 0x7
        sdv = 1'b1; seed = 16'h0007;
        tick();
        sdv = 1'b0;
        chk("seed7_load", 32'(d1_data), 32'h7);
        tick();
        chk("seed7_next", 32'(d1_data), 32'hE);
        repeat (14) tick();
        chk("seed7_wrap", 32'(d1_data), 32'h7);
        chk("seed7_done", 32'(d1_done), 32'h1);

        // Lock-up seed replaced by zero
        sdv = 1'b1; seed = 16'h000F;
        tick();
        sdv = 1'b0;
        chk("lock_data", 32'(d1_data), 32'h0);
        chk("lock_err", 32'(d1_err), 32'h1);
        tick();
        chk("lock_err_clr", 32'(d1_err), 32'h0);
        chk("lock_seq1", 32'(d1_data), 32'h1);
        tick();
        chk("lock_seq3", 32'(d1_data), 32'h3);
        tick();
        chk("lock_seq7", 32'(d1_data), 32'h7);

        // Ready pattern 1,0,0,1 then enable low for three cycles
        rdy = 1'b1; tick();
        rdy = 1'b0; tick();
        tick();
        rdy = 1'b1; tick();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("valid_low_disabled", 32'(d1_valid), 32'h0);
            tick();
        end
        en = 1'b1;
        tick();

        // Randomised traffic, including seeds colliding with transfers
        for (int k = 0; k < 400; k++) begin
            en   = ($urandom_range(0, 3) != 0);
            rdy  = 1'($urandom_range(0, 1));
            sdv  = ($urandom_range(0, 15) == 0);
            seed = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            tick();
        end
        sdv = 1'b0;

        // Full period of the 16-bit generator: exactly one completion pulse
        en = 1'b1; rdy = 1'b1; sdv = 1'b1; seed = 16'h0001;
        tick();
        sdv = 1'b0;
        d16_dones = 0;
        repeat (8195) begin
            tick();
            if (d16_done) d16_dones++;
        end
        chk("d16_done_count", 32'(d16_dones), 32'd1);

        // Asynchronous reset between clock edges
        repeat (3) tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 32'({d1_valid, d4_valid, d16_valid}), 32'h0);
        chk("arst_data", 32'({d1_data, d4_data, d16_data}), 32'h0);
        chk("arst_word", 32'({d1_word, d4_word, d16_word}), 32'h0);
        chk("arst_flags", 32'({d1_done, d4_done, d16_done, d1_err, d4_err, d16_err}), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("restart0", 32'(d1_data), 32'h0);
        tick();
        chk("restart1", 32'(d1_data), 32'h1);
        tick();
        chk("restart3", 32'(d1_data), 32'h3);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL have parameter NUM_BITS, default 16, LFSR state width, legal range 3..32.
REQ-002 SHALL have parameter OUT_BITS, default 8, single-bit LFSR steps per transfer and output word width, legal range 1..NUM_BITS.
REQ-003 SHALL have port i_Clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port i_Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_Enable  input  1  generator run enable; low holds all state.
REQ-006 SHALL have port i_Seed_DV  input  1  seed load strobe, one cycle.
REQ-007 SHALL have port i_Seed_Data  input  NUM_BITS  seed value, sampled when i_Seed_DV=1.
REQ-008 SHALL have port i_Ready  input  1  consumer accepts o_Word this cycle.
REQ-009 SHALL have port o_Valid  output  1  o_Word is available.
REQ-010 SHALL have port o_LFSR_Data  output  NUM_BITS  current LFSR state, registered.
REQ-011 SHALL have port o_Word  output  OUT_BITS  o_LFSR_Data[OUT_BITS-1:0].
REQ-012 SHALL have port o_LFSR_Done  output  1  one-cycle pulse on completion of a full period.
REQ-013 SHALL have port o_Seed_Err  output  1  one-cycle pulse: illegal (lock-up) seed replaced.

Function
REQ-014 SHALL implement a Fibonacci XNOR LFSR: one step = state <= {state[NUM_BITS-2:0], fb}, fb = XNOR of tap bits; taps per the XAPP052 maximal-length table for NUM_BITS 3..32; NUM_BITS=4 taps = bits 3,2.
REQ-015 SHALL perform OUT_BITS steps combinationally within one cycle (leap-forward) per transfer.
REQ-016 SHALL have two-state FSM: IDLE, RUN.
REQ-017 IDLE -> RUN SHALL occur on the edge where i_Seed_DV=1 or i_Enable=1; RUN never returns to IDLE except via reset.
REQ-018 o_Valid SHALL equal (FSM==RUN) AND i_Enable, combinational from registered state.
REQ-019 Transfer SHALL be o_Valid AND i_Ready; on transfer, state advances OUT_BITS steps at that edge; o_Word valid in the same cycle as o_Valid (zero latency), next word visible the following cycle.
REQ-020 With no transfer (i_Ready=0 or i_Enable=0), state, o_Word and step counter SHALL hold.
REQ-021 i_Seed_DV=1 SHALL load i_Seed_Data into the state at the edge, in any FSM state and regardless of i_Enable, and clear the step counter.
REQ-022 i_Seed_DV SHALL take priority over a simultaneous transfer: seed loaded, no step taken, transferred word was the pre-load o_Word.
REQ-023 A seed equal to all ones (XNOR lock-up) SHALL load all zeros instead, with o_Seed_Err=1 for the following cycle only.
REQ-024 Step counter, NUM_BITS wide, SHALL update on transfer to (cnt+OUT_BITS) mod (2^NUM_BITS-1).
REQ-025 o_LFSR_Done SHALL be 1 for exactly the cycle after a transfer whose counter addition reaches or crosses 2^NUM_BITS-1; otherwise 0.
REQ-026 Counter arithmetic SHALL use NUM_BITS+1 bits internally to avoid overflow before modulo.

Reset
REQ-027 While i_Rst_n=0: FSM=IDLE, state=0, counter=0, o_Valid=0, o_LFSR_Data=0, o_Word=0, o_LFSR_Done=0, o_Seed_Err=0.
REQ-028 Reset asserted mid-operation SHALL discard state immediately (asynchronous), independent of i_Clk.
REQ-029 Release SHALL be sampled synchronously; first transfer possible on the first edge after release with i_Enable=1 and FSM reached RUN.

Verification
REQ-030 N=4, OUT=1, reset, i_Enable=1, i_Ready=1, no seed -> o_LFSR_Data sequence 0,1,3,7,E,D,B,6,C,9,2,5,A,4,8,0; o_LFSR_Done pulses once, when state returns to 0 after the 15th transfer.
REQ-031 N=4, OUT=1, seed 0x7 with i_Seed_DV one cycle, then run -> E,D,B,...; o_LFSR_Done after 15 transfers with state back at 0x7.
REQ-032 N=4, OUT=1, seed 0xF -> state 0x0, o_Seed_Err high exactly one cycle; sequence continues 1,3,7.
REQ-033 N=4, OUT=1, i_Ready toggled 1,0,0,1 and i_Enable dropped for 3 cycles -> state advances only on o_Valid&&i_Ready cycles; o_Valid=0 while i_Enable=0; no step lost or duplicated.
REQ-034 N=4, OUT=4, from reset state 0 -> one transfer yields state 0xE; o_LFSR_Done after the 4th transfer (cnt 0,4,8,12,1).
REQ-035 Reset pulsed mid-run between clock edges -> all outputs 0 immediately; after release sequence restarts at 0,1,3.
